store_align_unit: RTL and testbench

STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

---
 rtl/store_align_if.sv | 52 +++++
 rtl/store_align_unit.sv | 182 ++++++++++++++++++
 tb/tb_store_align_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/store_align_if.sv
// ---------------------------------------------------------------------------
// store_align_if
//
// Purpose : bundles the store-request handshake (MEM stage side) and the
//           data-memory write port of store_align_unit into one interface.
//
// Signals :
//   st_valid   store request from the MEM stage
//   st_ready   unit can accept a request this cycle
//   st_addr    byte address of the store                 [ADDR_W]
//   st_data    register value (low byte/half for narrow) [32]
//   st_size    00 byte, 01 half, 10 word, 11 reserved    [2]
//   mem_req    data-memory write request
//   mem_addr   word-aligned write address                [ADDR_W]
//   mem_wdata  lane-replicated write data                [32]
//   mem_be     byte enables, bit i -> lane i             [4]
//   mem_ack    memory accepted the write this cycle
//   fault      one-cycle pulse on a rejected request
//   store_cnt  count of completed memory writes          [16]
//
// Modports:
//   slave  - the store_align_unit view
//   master - the environment view (pipeline + memory)
// ---------------------------------------------------------------------------
interface store_align_if #(
    parameter int ADDR_W = 32
);
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [1:0]        st_size;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ack;

    logic              fault;
    logic [15:0]       store_cnt;

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_ack,
        output st_ready, mem_req, mem_addr, mem_wdata, mem_be, fault, store_cnt
    );

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_ack,
        input  st_ready, mem_req, mem_addr, mem_wdata, mem_be, fault, store_cnt
    );
endinterface : store_align_if

// File: rtl/store_align_unit.sv
// ---------------------------------------------------------------------------
// store_align_unit
//
// Purpose : takes a byte/half/word store from the MEM stage, aligns it to a
//           32-bit word write (lane-replicated data plus byte enables) and
//           issues it to data memory, holding the write until mem_ack.
//           A two-state FSM (IDLE, ISSUE) gives at least 2 cycles per store.
//
// Ports   :
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    store_align_if.slave (request handshake, memory write port,
//          fault pulse and completed-write counter)
//
// Configuration:
//   STORE_MISALIGN_TRAP_EN  when defined, misaligned half/word stores are
//                           rejected like the reserved size (fault pulse, no
//                           write, no count). When undefined, the offending
//                           low address bits are ignored and the write goes
//                           ahead normally.
// ---------------------------------------------------------------------------
module store_align_unit #(
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    store_align_if.slave   bus
);

    // FSM encoding
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [0:0]        state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [31:0]       wdata_q,     wdata_d;
    logic [3:0]        be_q,        be_d;
    logic              fault_q,     fault_d;
    logic [15:0]       store_cnt_q, store_cnt_d;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    logic [1:0]  addr_lo;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic        size_reserved;
    logic        misaligned;
    logic        reject;
    logic        st_ready;
    logic        accept;

    assign addr_lo = bus.st_addr[1:0];

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        lane_wdata    = '0;
        lane_be       = '0;
        size_reserved = 1'b0;
        unique case (bus.st_size)
            SZ_BYTE: begin
                lane_wdata = {4{bus.st_data[7:0]}};
                lane_be    = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                // Only addr[1] picks the half; addr[0] is either trapped
                // below or deliberately ignored.
                lane_wdata = {2{bus.st_data[15:0]}};
                lane_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                lane_wdata = bus.st_data;
                lane_be    = 4'b1111;
            end
            default: begin
                size_reserved = 1'b1;
            end
        endcase
    end

`ifdef STORE_MISALIGN_TRAP_EN
    assign misaligned = ((bus.st_size == SZ_HALF) && addr_lo[0]) ||
                        ((bus.st_size == SZ_WORD) && (addr_lo != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign reject = size_reserved || misaligned;

    // Gated with rst_n so the handshake drops the moment reset asserts and
    // is available for the first edge after release.
    assign st_ready = (state_q == S_IDLE) && rst_n;
    assign accept   = bus.st_valid && st_ready;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        fault_d     = 1'b0;
        store_cnt_d = store_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                // mem_ack is don't-care here
                if (accept) begin
                    if (reject) begin
                        // Accepted but dropped: flag it, stay in IDLE.
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        addr_d  = {bus.st_addr[ADDR_W-1:2], 2'b00};
                        wdata_d = lane_wdata;
                        be_d    = lane_be;
                    end
                end
            end
            S_ISSUE: begin
                // st_valid is don't-care here; fields stay frozen until ack.
                if (bus.mem_ack) begin
                    state_d     = S_IDLE;
                    store_cnt_d = store_cnt_q + 16'd1;  // wraps at 0xFFFF
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the async reset clears all of it, which also
    // abandons (and never counts) a write that is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            fault_q     <= 1'b0;
            store_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            fault_q     <= fault_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    logic mem_req;

    assign mem_req = (state_q == S_ISSUE);

    // Bus is driven to zero outside ISSUE so memory never sees stale lanes.
    assign bus.st_ready  = st_ready;
    assign bus.mem_req   = mem_req;
    assign bus.mem_addr  = mem_req ? addr_q  : '0;
    assign bus.mem_wdata = mem_req ? wdata_q : '0;
    assign bus.mem_be    = mem_req ? be_q    : '0;
    assign bus.fault     = fault_q;
    assign bus.store_cnt = store_cnt_q;

endmodule : store_align_unit

// File: tb/tb_store_align_unit.sv
// ---------------------------------------------------------------------------
// tb_store_align_unit
//
// Directed-vector bench for store_align_unit. Inputs change on the falling
// edge, outputs are sampled on the falling edge. Expected values are
// hand-computed constants; exp_cnt tracks the completed-write count.
// Expectations for misaligned stores follow STORE_MISALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
module tb_store_align_unit;

    localparam int ADDR_W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    store_align_if #(.ADDR_W(ADDR_W)) bus ();

    store_align_unit #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          errors  = 0;
    int          checks  = 0;
    logic [15:0] exp_cnt = '0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.st_size  = 2'b00;
        bus.mem_ack  = 1'b0;
    endtask

    // Full store: accept, nwait ISSUE cycles with ack low, then ack.
    // With noise set, st_valid stays high with junk during ISSUE.
    task automatic do_store(input string tag, input logic [31:0] addr,
                            input logic [31:0] data, input logic [1:0] size,
                            input int nwait, input bit noise,
                            input logic [31:0] e_addr, input logic [31:0] e_wdata,
                            input logic [3:0] e_be);
        @(negedge clk);
        check($sformatf("%s.ready_idle", tag), bus.st_ready, 1);
        bus.st_valid = 1'b1;
        bus.st_addr  = addr;
        bus.st_data  = data;
        bus.st_size  = size;
        @(negedge clk);
        bus.st_valid = noise;
        if (noise) begin
            bus.st_addr = 32'hFFFF_FFFF;
            bus.st_data = 32'h0000_0000;
            bus.st_size = 2'b10;
        end
        for (int i = 0; i <= nwait; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("%s.req[%0d]",   tag, i), bus.mem_req,   1);
            check($sformatf("%s.addr[%0d]",  tag, i), bus.mem_addr,  e_addr);
            check($sformatf("%s.wdata[%0d]", tag, i), bus.mem_wdata, e_wdata);
            check($sformatf("%s.be[%0d]",    tag, i), bus.mem_be,    e_be);
            check($sformatf("%s.ready[%0d]", tag, i), bus.st_ready,  0);
            if (i == nwait) bus.mem_ack = 1'b1;
        end
        @(negedge clk);
        bus.mem_ack  = 1'b0;
        bus.st_valid = 1'b0;
        exp_cnt++;
        check($sformatf("%s.req_done", tag),   bus.mem_req,   0);
        check($sformatf("%s.wdata_done", tag), bus.mem_wdata, 0);
        check($sformatf("%s.be_done", tag),    bus.mem_be,    0);
        check($sformatf("%s.cnt", tag),        bus.store_cnt, exp_cnt);
        check($sformatf("%s.ready_done", tag), bus.st_ready,  1);
    endtask

    // Request that must be accepted, flagged by one fault pulse, and dropped.
    task automatic do_reject(input string tag, input logic [31:0] addr,
                             input logic [31:0] data, input logic [1:0] size);
        @(negedge clk);
        bus.st_valid = 1'b1;
        bus.st_addr  = addr;
        bus.st_data  = data;
        bus.st_size  = size;
        @(negedge clk);
        bus.st_valid = 1'b0;
        check($sformatf("%s.fault", tag), bus.fault,     1);
        check($sformatf("%s.req", tag),   bus.mem_req,   0);
        check($sformatf("%s.be", tag),    bus.mem_be,    0);
        check($sformatf("%s.ready", tag), bus.st_ready,  1);
        check($sformatf("%s.cnt", tag),   bus.store_cnt, exp_cnt);
        @(negedge clk);
        check($sformatf("%s.fault_end", tag), bus.fault,     0);
        check($sformatf("%s.req_end", tag),   bus.mem_req,   0);
        check($sformatf("%s.cnt_end", tag),   bus.store_cnt, exp_cnt);
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;

        // ---- reset state ----
        #2;
        check("rst.ready", bus.st_ready,  0);
        check("rst.req",   bus.mem_req,   0);
        check("rst.addr",  bus.mem_addr,  0);
        check("rst.wdata", bus.mem_wdata, 0);
        check("rst.be",    bus.mem_be,    0);
        check("rst.fault", bus.fault,     0);
        check("rst.cnt",   bus.store_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst.ready_after", bus.st_ready, 1);

        // ---- lane alignment ----
        do_store("byte13", 32'h0000_0013, 32'h1234_56AB, 2'b00, 1, 1'b0,
                 32'h0000_0010, 32'hABAB_ABAB, 4'b1000);
        do_store("half22", 32'h0000_0022, 32'hFFFF_8001, 2'b01, 3, 1'b1,
                 32'h0000_0020, 32'h8001_8001, 4'b1100);
        do_store("half20", 32'h0000_0020, 32'h0000_BEEF, 2'b01, 0, 1'b0,
                 32'h0000_0020, 32'hBEEF_BEEF, 4'b0011);
        do_store("byte01", 32'h0000_0001, 32'hFFFF_FF55, 2'b00, 0, 1'b0,
                 32'h0000_0000, 32'h5555_5555, 4'b0010);
        do_store("word08", 32'h0000_0008, 32'hDEAD_BEEF, 2'b10, 2, 1'b0,
                 32'h0000_0008, 32'hDEAD_BEEF, 4'b1111);

        // ---- misaligned half/word ----
`ifdef STORE_MISALIGN_TRAP_EN
        do_reject("word06", 32'h0000_0006, 32'hCAFE_F00D, 2'b10);
        do_reject("half23", 32'h0000_0023, 32'h1234_ABCD, 2'b01);
`else
        do_store("word06", 32'h0000_0006, 32'hCAFE_F00D, 2'b10, 0, 1'b0,
                 32'h0000_0004, 32'hCAFE_F00D, 4'b1111);
        do_store("half23", 32'h0000_0023, 32'h1234_ABCD, 2'b01, 1, 1'b0,
                 32'h0000_0020, 32'hABCD_ABCD, 4'b1100);
`endif

        // ---- reserved size alone ----
        do_reject("rsv", 32'h0000_0030, 32'h1111_2222, 2'b11);

        // ---- reserved size followed immediately by a word store ----
        @(negedge clk);
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'h0000_0040;
        bus.st_data  = 32'h0000_0000;
        bus.st_size  = 2'b11;
        @(negedge clk);
        check("rsv2.fault", bus.fault,    1);
        check("rsv2.req",   bus.mem_req,  0);
        check("rsv2.ready", bus.st_ready, 1);
        bus.st_addr = 32'h0000_0044;
        bus.st_data = 32'h0102_0304;
        bus.st_size = 2'b10;
        @(negedge clk);
        bus.st_valid = 1'b0;
        check("rsv2.fault_end", bus.fault,     0);
        check("rsv2.w_req",     bus.mem_req,   1);
        check("rsv2.w_addr",    bus.mem_addr,  32'h0000_0044);
        check("rsv2.w_wdata",   bus.mem_wdata, 32'h0102_0304);
        check("rsv2.w_be",      bus.mem_be,    4'b1111);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        exp_cnt++;
        check("rsv2.w_done", bus.mem_req,   0);
        check("rsv2.cnt",    bus.store_cnt, exp_cnt);
        check("rsv2.fault2", bus.fault,     0);

        // ---- mem_ack in IDLE is ignored ----
        @(negedge clk);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("idle_ack.cnt", bus.store_cnt, exp_cnt);
        check("idle_ack.req", bus.mem_req,   0);

        // ---- reset during the second ISSUE cycle ----
        @(negedge clk);
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'h0000_0010;
        bus.st_data  = 32'h0000_0011;
        bus.st_size  = 2'b00;
        @(negedge clk);
        bus.st_valid = 1'b0;
        check("rst_mid.req1", bus.mem_req, 1);
        @(negedge clk);
        check("rst_mid.req2", bus.mem_req, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid.req",   bus.mem_req,   0);
        check("rst_mid.addr",  bus.mem_addr,  0);
        check("rst_mid.wdata", bus.mem_wdata, 0);
        check("rst_mid.be",    bus.mem_be,    0);
        check("rst_mid.cnt",   bus.store_cnt, 0);
        check("rst_mid.ready", bus.st_ready,  0);
        exp_cnt = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.st_valid = 1'b1;
        bus.st_addr  = 32'h0000_0003;
        bus.st_data  = 32'h0000_0077;
        bus.st_size  = 2'b00;
        @(negedge clk);
        bus.st_valid = 1'b0;
        check("post_rst.req",   bus.mem_req,   1);
        check("post_rst.addr",  bus.mem_addr,  32'h0000_0000);
        check("post_rst.wdata", bus.mem_wdata, 32'h7777_7777);
        check("post_rst.be",    bus.mem_be,    4'b1000);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        exp_cnt++;
        check("post_rst.cnt", bus.store_cnt, exp_cnt);

        // ---- counter wrap: preload to 0xFFFF, then store ----
        @(negedge clk);
        force dut.store_cnt_q = 16'hFFFF;
        #1 release dut.store_cnt_q;
        #1;
        exp_cnt = 16'hFFFF;
        check("wrap.preload", bus.store_cnt, exp_cnt);
        do_store("wrap", 32'h0000_0100, 32'hA5A5_5A5A, 2'b10, 0, 1'b0,
                 32'h0000_0100, 32'hA5A5_5A5A, 4'b1111);
        check("wrap.zero", bus.store_cnt, 16'h0000);
        do_store("wrap1", 32'h0000_0102, 32'h0000_C3C3, 2'b01, 0, 1'b0,
                 32'h0000_0100, 32'hC3C3_C3C3, 4'b1100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_store_align_unit
